// File: rtl/data_mem_responder.sv
// Round-robin load/store responder over a DEPTH-word array; Req seen in IDLE -> Ack two edges later.
// One request in flight; others hold Req high and wait for Ack, served at most NUM_PORTS grants later.
module data_mem_responder #(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NUM_PORTS-1:0]   Req,
    input  logic [NUM_PORTS-1:0]   MemWrite,
    input  logic [NUM_PORTS-1:0]   HalfCtl,
    input  logic [NUM_PORTS-1:0]   ByteCtl,
    input  logic [32*NUM_PORTS-1:0] Addr,
    input  logic [32*NUM_PORTS-1:0] WData,
    output logic [NUM_PORTS-1:0]   Ack,
    output logic [31:0]            RData,
    output logic                   Busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant;
    logic [PW-1:0]     sel;
    logic              sel_vld;
    logic              op_write;
    logic              op_half;
    logic              op_byte;
    logic [ADDR_W+1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [31:0]       rd_word;
    logic [31:0]       rdata_q;
    logic [31:0]       load_ext;
    logic [3:0]        be;
    logic [31:0]       wr_word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       mem [DEPTH];

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (Req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
                sel     = PW'((int'(rr_ptr) + i) % NUM_PORTS);
                sel_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr   <= '0;
            grant    <= '0;
            op_write <= 1'b0;
            op_half  <= 1'b0;
            op_byte  <= 1'b0;
            op_addr  <= '0;
            op_wdata <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == IDLE && sel_vld) begin
                grant    <= sel;
                op_write <= MemWrite[sel];
                op_half  <= HalfCtl[sel];
                op_byte  <= ByteCtl[sel];
                op_addr  <= Addr[32*sel +: ADDR_W+2];
                op_wdata <= WData[32*sel +: 32];
            end
            if (state == RESP) begin
                rr_ptr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                if (!op_write) begin
                    rdata_q <= load_ext;
                end
            end
        end
    end

    assign word_idx = op_addr[ADDR_W+1:2];

    always_comb begin
        be      = 4'b1111;
        wr_word = op_wdata;
        if (op_byte) begin
            be              = 4'b0000;
            be[op_addr[1:0]] = 1'b1;
            wr_word         = {4{op_wdata[7:0]}};
        end else if (op_half) begin
            be      = op_addr[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{op_wdata[15:0]}};
        end
    end

    // Array has no reset; its contents survive Reset_n.
    always_ff @(posedge Clk) begin
        if (state == ACCESS) begin
            if (op_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end else begin
                rd_word <= mem[word_idx];
            end
        end
    end

    always_comb begin
        byte_v   = rd_word[{op_addr[1:0], 3'b000} +: 8];
        half_v   = rd_word[{op_addr[1], 4'b0000} +: 16];
        load_ext = rd_word;
        if (op_byte) begin
            load_ext = {{24{byte_v[7]}}, byte_v};
        end else if (op_half) begin
            load_ext = {{16{half_v[15]}}, half_v};
        end
    end

    always_comb begin
        Ack   = '0;
        RData = rdata_q;
        Busy  = (state != IDLE);
        if (state == RESP) begin
            Ack[grant] = 1'b1;
            if (!op_write) RData = load_ext;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: per-port expected-response queues filled at issue,
// drained by a monitor that compares on every Ack against a word-array reference model.
module tb_data_mem_responder;

    localparam int NP    = 2;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NP-1:0]       req;
    logic [NP-1:0]       mem_write;
    logic [NP-1:0]       half_ctl;
    logic [NP-1:0]       byte_ctl;
    logic [32*NP-1:0]    addr;
    logic [32*NP-1:0]    wdata;
    logic [NP-1:0]       ack;
    logic [31:0]         rdata;
    logic                busy;

    data_mem_responder #(.NUM_PORTS(NP), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .Clk(clk), .Reset_n(rst_n), .Req(req), .MemWrite(mem_write),
        .HalfCtl(half_ctl), .ByteCtl(byte_ctl), .Addr(addr), .WData(wdata),
        .Ack(ack), .RData(rdata), .Busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [NP][$];
    logic [31:0] model_mem [DEPTH];
    bit          word_init [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          wait_cnt [NP];
    logic [31:0] last_rd;
    int          ack_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input bit h, input bit b);
        logic [31:0] w;
        logic [7:0]  bv;
        logic [15:0] hv;
        w = model_mem[int'(a[AW+1:2])];
        if (b) begin
            bv = 8'(w >> (8 * int'(a[1:0])));
            return {{24{bv[7]}}, bv};
        end
        if (h) begin
            hv = 16'(w >> (16 * int'(a[1])));
            return {{16{hv[15]}}, hv};
        end
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input bit h, input bit b, input logic [31:0] d);
        int          idx;
        logic [31:0] mask;
        logic [31:0] val;
        idx = int'(a[AW+1:2]);
        if (b) begin
            mask = 32'h0000_00FF << (8 * int'(a[1:0]));
            val  = (d & 32'h0000_00FF) << (8 * int'(a[1:0]));
        end else if (h) begin
            mask = 32'h0000_FFFF << (16 * int'(a[1]));
            val  = (d & 32'h0000_FFFF) << (16 * int'(a[1]));
        end else begin
            mask = 32'hFFFF_FFFF;
            val  = d;
        end
        model_mem[idx] = (model_mem[idx] & ~mask) | val;
    endtask

    task automatic do_op(input int p, input bit wr, input bit h, input bit b,
                         input logic [31:0] a, input logic [31:0] d,
                         input int exp_lat, input string name);
        exp_t e;
        int   n;
        e.is_load = !wr;
        e.data    = '0;
        if (wr) model_store(a, h, b, d);
        else    e.data = model_load(a, h, b);
        exp_q[p].push_back(e);
        @(negedge clk);
        mem_write[p]      = wr;
        half_ctl[p]       = h;
        byte_ctl[p]       = b;
        addr[32*p +: 32]  = a;
        wdata[32*p +: 32] = d;
        req[p]            = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[p] && n < 100);
        check({name, "_ack"}, 32'(ack[p]), 32'd1);
        if (exp_lat >= 0) check({name, "_latency"}, 32'(n), 32'(exp_lat));
        req[p] = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_rd = '0;
                for (int q = 0; q < NP; q++) wait_cnt[q] = 0;
            end else if (ack != '0) begin
                check("ack_onehot", 32'($countones(ack)), 32'd1);
                check("busy_in_resp", 32'(busy), 32'd1);
                for (int p = 0; p < NP; p++) begin
                    if (ack[p]) begin
                        ack_log.push_back(p);
                        if (exp_q[p].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_ack: port %0d acked with nothing outstanding", p);
                        end else begin
                            e = exp_q[p].pop_front();
                            if (e.is_load) begin
                                check($sformatf("rdata_p%0d", p), rdata, e.data);
                                last_rd = e.data;
                            end else begin
                                check($sformatf("rdata_hold_p%0d", p), rdata, last_rd);
                            end
                        end
                        check($sformatf("fair_p%0d", p), 32'(wait_cnt[p] <= NP - 1), 32'd1);
                        wait_cnt[p] = 0;
                        for (int q = 0; q < NP; q++) begin
                            if (q != p && req[q]) wait_cnt[q]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic rand_stream(input int p, input int nops);
        int          w;
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < nops; i++) begin
            w = 64 + 64 * p + int'($urandom_range(0, 63));
            a = ($urandom & ~32'(4 * DEPTH - 1)) | 32'(w << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            kind = word_init[w] ? int'($urandom_range(0, 5)) : 0;
            word_init[w] = 1'b1;
            case (kind)
                0: do_op(p, 1'b1, 1'b0, 1'b0, a, d, -1, "rnd_sw");
                1: do_op(p, 1'b1, 1'b1, 1'b0, a, d, -1, "rnd_sh");
                2: do_op(p, 1'b1, 1'b0, 1'b1, a, d, -1, "rnd_sb");
                3: do_op(p, 1'b0, 1'b0, 1'b0, a, d, -1, "rnd_lw");
                4: do_op(p, 1'b0, 1'b1, 1'b0, a, d, -1, "rnd_lh");
                default: do_op(p, 1'b0, 1'b0, 1'b1, a, d, -1, "rnd_lb");
            endcase
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        rst_n = 1'b0;
        req = '0; mem_write = '0; half_ctl = '0; byte_ctl = '0; addr = '0; wdata = '0;
        last_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
            word_init[i] = 1'b0;
        end
        for (int q = 0; q < NP; q++) wait_cnt[q] = 0;
        fork
            monitor();
            begin
                #400000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Word store/load with first-request latency
        do_op(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, "t2_sw");
        do_op(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 2, "t2_lw");

        // Byte/half lanes; the byte store comes from the other port
        do_op(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1122_3344, 2, "t3_sw");
        do_op(1, 1'b1, 1'b0, 1'b1, 32'h22, 32'h0000_0080, 2, "t3_sb");
        do_op(0, 1'b0, 1'b0, 1'b1, 32'h22, 32'h0, 2, "t3_lb");
        do_op(1, 1'b0, 1'b1, 1'b0, 32'h22, 32'h0, 2, "t3_lh");
        do_op(0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 2, "t3_lw");
        do_op(1, 1'b1, 1'b1, 1'b0, 32'h31, 32'h1234_8001, -1, "t3_sh");
        do_op(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, -1, "t3_lh0");
        do_op(0, 1'b0, 1'b0, 1'b1, 32'h31, 32'h0, -1, "t3_lb1");

        // Index wraps modulo DEPTH
        do_op(0, 1'b1, 1'b0, 1'b0, 32'(4 * DEPTH + 4), 32'hA5A5_A5A5, -1, "t5_sw");
        do_op(1, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, -1, "t5_lw");

        // Reset during RESP: outputs clear at once, the aborted Ack never reappears
        e.is_load = 1'b1;
        e.data    = model_load(32'h10, 1'b0, 1'b0);
        exp_q[0].push_back(e);
        @(negedge clk);
        mem_write[0] = 1'b0; half_ctl[0] = 1'b0; byte_ctl[0] = 1'b0;
        addr[31:0] = 32'h10; req[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[0] && n < 100);
        check("t1_ack_before_reset", 32'(ack[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_ack", 32'(ack), 32'd0);
        check("t1_rdata", rdata, 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t1_no_late_ack", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        // Simultaneous requests from reset: p0 first, p1 three cycles later
        fork
            do_op(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 2, "t4_p0");
            do_op(1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 5, "t4_p1");
        join

        // Continuous requests alternate between ports
        ack_log.delete();
        fork
            repeat (6) do_op(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, -1, "t4_s0");
            repeat (6) do_op(1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, -1, "t4_s1");
        join
        check("t4_log_len", 32'(ack_log.size()), 32'd12);
        for (int i = 1; i < ack_log.size(); i++) begin
            check($sformatf("t4_alternate_%0d", i), 32'(ack_log[i] != ack_log[i-1]), 32'd1);
        end

        // One port streams while the other waits with Req held
        fork
            repeat (5) do_op(0, 1'b1, 1'b0, 1'b0, 32'h40, $urandom, -1, "t6_stream");
            begin
                @(negedge clk);
                do_op(1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, -1, "t6_stall");
            end
        join

        // Randomized traffic on both ports in disjoint regions
        fork
            rand_stream(0, 60);
            rand_stream(1, 60);
        join

        repeat (4) @(negedge clk);
        check("end_queues_empty", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
